fft_input_loader: RTL and testbench
===================================

FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 Parameter N_LOG2, default 10, log2 of frame length (1024 points); RAM address width.
REQ-002 Parameter DATA_W, default 32, sample and RAM word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that arms capture of one frame.
REQ-006 s_valid  input  1  upstream sample valid.
REQ-007 s_data  input  DATA_W  upstream real sample, two's complement.
REQ-008 s_ready  output  1  loader accepts a sample this cycle.
REQ-009 address_a  output  N_LOG2  RAM port A address.
REQ-010 address_b  output  N_LOG2  RAM port B address.
REQ-011 dreal_a, dreal_b  output  DATA_W each  real write data for ports A and B.
REQ-012 dimg_a, dimg_b  output  DATA_W each  imaginary write data for ports A and B.
REQ-013 wren  output  1  shared write enable for both RAM ports and both RAM halves.
REQ-014 busy  output  1  high in LOAD and FLUSH.
REQ-015 frame_ready  output  1  full frame resident in RAM, held until acknowledged.
REQ-016 frame_ack  input  1  downstream FFT has taken the frame.

Function
REQ-017 FSM states: IDLE, LOAD, FLUSH, DONE.
REQ-018 Transitions: IDLE->LOAD on start; LOAD->FLUSH on acceptance of sample 2^N_LOG2-1; FLUSH->DONE after one cycle; DONE->IDLE on frame_ack.
REQ-019 Acceptance: a sample is taken when s_valid && s_ready; s_ready = 1 only in LOAD; s_ready is combinational from state only, never from s_valid.
REQ-020 Sample counter n (N_LOG2 bits) clears on entry to LOAD and increments per accepted sample.
REQ-021 Even-index sample (n[0]=0) is held in a pair register; no RAM write.
REQ-022 Odd-index sample n=2k+1 accepted in cycle t: in cycle t+1 wren=1, address_a=bitrev(2k), address_b=bitrev(2k+1), dreal_a=even sample, dreal_b=odd sample, dimg_a=dimg_b=0.
REQ-023 bitrev reverses all N_LOG2 address bits; A and B addresses differ only in MSB, so the two ports never collide.
REQ-024 wren is a registered single-cycle pulse; 0 in every cycle without a completed pair.
REQ-025 Final pair write (samples 1022/1023) occurs in the FLUSH cycle; frame_ready rises the following cycle (DONE entry).
REQ-026 start is ignored outside IDLE; frame_ack is ignored outside DONE.
REQ-027 start and frame_ack asserted in the same DONE cycle: return to IDLE only; start not captured.
REQ-028 s_valid gaps in LOAD stall the counter; pair register holds its value indefinitely.
REQ-029 Data path width is preserved: no truncation, rounding or sign extension of s_data.

Reset
REQ-030 On rst: state=IDLE, n=0, pair register=0, s_ready=0, wren=0, addresses=0, all data outputs=0, busy=0, frame_ready=0.
REQ-031 rst mid-LOAD discards the partial frame; no further writes occur; next frame needs a new start.

Structure
REQ-032 N_LOG2, DATA_W defaults, and state encodings belong in shared package fft_pkg used by all FFT stages.
REQ-033 Address reversal is one sub-module, bit_reverse, parameterised by N_LOG2, purely combinational.
REQ-034 Outputs connect 1:1 to the dual-port complex RAM wrapper with no glue logic.

Verification
REQ-035 start, then 1024 back-to-back samples s_data=n -> 512 wren pulses; RAM real word at bitrev(n) equals n for all n; all imaginary words 0; frame_ready high 2 cycles after last accept.
REQ-036 First pair 5, 7 -> one cycle later wren=1, address_a=0, address_b=512, dreal_a=5, dreal_b=7.
REQ-037 s_valid toggling every other cycle -> same RAM contents as REQ-035; no wren on even-sample cycles.
REQ-038 rst asserted after 300 samples -> all outputs 0 immediately; no wren until next start; new frame loads correctly from n=0.
REQ-039 start pulsed during LOAD, frame_ack pulsed during LOAD -> no effect; frame_ack in DONE -> frame_ready falls next cycle, state IDLE.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame geometry and the loader state encoding.
package fft_pkg;

  localparam int FFT_N_LOG2 = 10;
  localparam int FFT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

endpackage

// File: rtl/bit_reverse.sv
// Purely combinational reversal of all N_LOG2 address bits.
module bit_reverse #(
  parameter int N_LOG2 = 10
) (
  input  logic [N_LOG2-1:0] addr_i,
  output logic [N_LOG2-1:0] addr_o
);

  for (genvar i = 0; i < N_LOG2; i++) begin : g_rev
    assign addr_o[i] = addr_i[N_LOG2-1-i];
  end

endmodule

// File: rtl/fft_input_loader.sv
// Packs a stream of real samples into even/odd pairs and writes them, bit-reversed,
// through both ports of the complex FFT RAM; signals when a full frame is resident.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     s_ready,
  output logic [N_LOG2-1:0]        address_a,
  output logic [N_LOG2-1:0]        address_b,
  output logic signed [DATA_W-1:0] dreal_a,
  output logic signed [DATA_W-1:0] dreal_b,
  output logic signed [DATA_W-1:0] dimg_a,
  output logic signed [DATA_W-1:0] dimg_b,
  output logic                     wren,
  output logic                     busy,
  output logic                     frame_ready,
  input  logic                     frame_ack
);

  load_state_e              state_q, state_d;
  logic [N_LOG2-1:0]        n_q, n_d;
  logic signed [DATA_W-1:0] pair_q, pair_d;
  logic                     wren_q, wren_d;
  logic [N_LOG2-1:0]        addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic signed [DATA_W-1:0] dreal_a_q, dreal_a_d, dreal_b_q, dreal_b_d;

  logic                     accept;
  logic [N_LOG2-1:0]        even_idx, rev_even, rev_odd;

  assign s_ready     = (state_q == ST_LOAD);
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign frame_ready = (state_q == ST_DONE);
  assign accept      = s_valid && s_ready;
  assign even_idx    = n_q & ~N_LOG2'(1);

  bit_reverse #(.N_LOG2(N_LOG2)) u_rev_a (.addr_i(even_idx), .addr_o(rev_even));
  bit_reverse #(.N_LOG2(N_LOG2)) u_rev_b (.addr_i(n_q),      .addr_o(rev_odd));

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    pair_d    = pair_q;
    wren_d    = 1'b0;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    dreal_a_d = dreal_a_q;
    dreal_b_d = dreal_b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          n_d     = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          n_d = n_q + N_LOG2'(1);
          // Even sample waits in the pair register; odd sample completes the pair.
          if (!n_q[0]) begin
            pair_d = s_data;
          end else begin
            wren_d    = 1'b1;
            addr_a_d  = rev_even;
            addr_b_d  = rev_odd;
            dreal_a_d = pair_q;
            dreal_b_d = s_data;
          end
          if (&n_q) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE: begin
        if (frame_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      pair_q    <= '0;
      wren_q    <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      dreal_a_q <= '0;
      dreal_b_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      pair_q    <= pair_d;
      wren_q    <= wren_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      dreal_a_q <= dreal_a_d;
      dreal_b_q <= dreal_b_d;
    end
  end

  assign wren      = wren_q;
  assign address_a = addr_a_q;
  assign address_b = addr_b_q;
  assign dreal_a   = dreal_a_q;
  assign dreal_b   = dreal_b_q;
  assign dimg_a    = '0;
  assign dimg_b    = '0;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader with a write scoreboard and a RAM model.
module tb_fft_input_loader;

  localparam int N_LOG2 = 10;
  localparam int DATA_W = 32;
  localparam int NPTS   = 1 << N_LOG2;

  logic                     clk, rst, start, s_valid, frame_ack;
  logic signed [DATA_W-1:0] s_data;
  logic                     s_ready, wren, busy, frame_ready;
  logic [N_LOG2-1:0]        address_a, address_b;
  logic signed [DATA_W-1:0] dreal_a, dreal_b, dimg_a, dimg_b;

  fft_input_loader #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .address_a(address_a), .address_b(address_b),
    .dreal_a(dreal_a), .dreal_b(dreal_b), .dimg_a(dimg_a), .dimg_b(dimg_b),
    .wren(wren), .busy(busy), .frame_ready(frame_ready), .frame_ack(frame_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_LOG2-1:0] aa;
    logic [N_LOG2-1:0] ab;
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
  } wr_t;

  wr_t               sb_q[$];
  int                checks = 0;
  int                errors = 0;
  int                m_state;
  logic [N_LOG2-1:0] m_n;
  logic [DATA_W-1:0] m_pair;
  logic [DATA_W-1:0] ram_re [NPTS];
  logic [DATA_W-1:0] ram_im [NPTS];
  logic [DATA_W-1:0] sent   [NPTS];

  function automatic logic [N_LOG2-1:0] brev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = a[N_LOG2-1-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_n     = '0;
    m_pair  = '0;
    sb_q.delete();
  endtask

  task automatic clear_ram();
    for (int i = 0; i < NPTS; i++) begin
      ram_re[i] = 32'hDEAD_BEEF;
      ram_im[i] = 32'hDEAD_BEEF;
    end
  endtask

  // One clock: advance the model with the current inputs, then check the DUT after the edge.
  task automatic step();
    wr_t e;
    if (rst) begin
      model_reset();
    end else begin
      case (m_state)
        0: if (start) begin m_state = 1; m_n = '0; end
        1: if (s_valid) begin
             if (!m_n[0]) m_pair = s_data;
             else begin
               e.aa = brev(m_n & ~N_LOG2'(1));
               e.ab = brev(m_n);
               e.ra = m_pair;
               e.rb = s_data;
               sb_q.push_back(e);
             end
             if (m_n == N_LOG2'(NPTS - 1)) m_state = 2;
             m_n = m_n + N_LOG2'(1);
           end
        2: m_state = 3;
        default: if (frame_ack) m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
    if (wren === 1'b1) begin
      ram_re[address_a] = dreal_a;
      ram_re[address_b] = dreal_b;
      ram_im[address_a] = dimg_a;
      ram_im[address_b] = dimg_b;
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("wren_pair", 64'(wren), 64'(1));
      chk("address_a", 64'(address_a), 64'(e.aa));
      chk("address_b", 64'(address_b), 64'(e.ab));
      chk("dreal_a", 64'(dreal_a), 64'(e.ra));
      chk("dreal_b", 64'(dreal_b), 64'(e.rb));
      chk("dimg_ab", {dimg_a, dimg_b}, 64'(0));
    end else begin
      chk("wren_idle", 64'(wren), 64'(0));
    end
    chk("ctrl_rdy_busy_frdy", 64'({s_ready, busy, frame_ready}),
        64'({m_state == 1, (m_state == 1) || (m_state == 2), m_state == 3}));
  endtask

  task automatic load_frame(input bit gaps, input int stop_at, input bit pair57);
    for (int i = 0; i < NPTS; i++) begin
      if (i == stop_at) return;
      if (gaps) begin
        s_valid = 1'b0;
        step();
      end
      s_valid = 1'b1;
      s_data  = (pair57 && i < 2) ? ((i == 0) ? 32'sd5 : 32'sd7) : DATA_W'(i);
      sent[i] = s_data;
      step();
      if (pair57 && i == 1) begin
        chk("p57_wren", 64'(wren), 64'(1));
        chk("p57_addr_a", 64'(address_a), 64'(0));
        chk("p57_addr_b", 64'(address_b), 64'(512));
        chk("p57_dreal_a", 64'(dreal_a), 64'(5));
        chk("p57_dreal_b", 64'(dreal_b), 64'(7));
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic check_ram();
    for (int i = 0; i < NPTS; i++) begin
      chk("ram_real", 64'(ram_re[brev(N_LOG2'(i))]), 64'(sent[i]));
      chk("ram_imag", 64'(ram_im[brev(N_LOG2'(i))]), 64'(0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({s_ready, wren, busy, frame_ready}), 64'(0));
    chk({tag, "_addr"}, 64'({address_a, address_b}), 64'(0));
    chk({tag, "_dreal"}, {dreal_a, dreal_b}, 64'(0));
    chk({tag, "_dimg"}, {dimg_a, dimg_b}, 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; frame_ack = 1'b0; s_data = '0;
    model_reset();
    clear_ram();
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Frame 1: back-to-back samples, first pair 5/7.
    start = 1'b1; step(); start = 1'b0;
    load_frame(1'b0, NPTS, 1'b1);
    step();
    chk("frame_ready_rise", 64'(frame_ready), 64'(1));
    check_ram();
    frame_ack = 1'b1; step(); frame_ack = 1'b0;
    chk("frame_ready_fall", 64'(frame_ready), 64'(0));
    chk("idle_after_ack", 64'({s_ready, busy}), 64'(0));

    // Frame 2: valid gaps, stray start/frame_ack inside LOAD.
    clear_ram();
    start = 1'b1; step(); start = 1'b0;
    start = 1'b1; frame_ack = 1'b1; step(); start = 1'b0; frame_ack = 1'b0;
    chk("stray_pulses_still_load", 64'({s_ready, busy}), 64'(3));
    load_frame(1'b1, NPTS, 1'b0);
    step();
    step(); step(); step();
    chk("frame_ready_held", 64'(frame_ready), 64'(1));
    check_ram();
    start = 1'b1; frame_ack = 1'b1; step(); start = 1'b0; frame_ack = 1'b0;
    step();
    chk("ack_plus_start_idle", 64'({s_ready, busy, frame_ready}), 64'(0));

    // Frame 3: reset after 300 samples, then reload from scratch.
    start = 1'b1; step(); start = 1'b0;
    load_frame(1'b0, 300, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    rst = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    s_valid = 1'b0;
    clear_ram();
    start = 1'b1; step(); start = 1'b0;
    load_frame(1'b0, NPTS, 1'b0);
    step();
    chk("frame_ready_after_rst", 64'(frame_ready), 64'(1));
    check_ram();
    frame_ack = 1'b1; step(); frame_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
